cmos_dvp_pattern_gen: RTL and testbench
=======================================

# cmos_dvp_pattern_gen

Synthetic OV7670-style DVP transmitter: drives vsync/href/8-bit byte stream of RGB565 test patterns with the same framing the CMOS capture path receives. Replaces the sensor in bring-up and simulation so the capture → SDRAM → VGA chain can be checked against a known, deterministic image. Outputs are registered. Downstream uses `clk` as its `cmos_pclk`.

## Interface
- `H_ACTIVE`, 640: active pixels per line. Each pixel is 2 bytes.
- `H_BLANK`, 288: byte clocks per line with href low.
- `V_ACTIVE`, 480: active lines per frame.
- `VSYNC_LINES`, 3: lines with vsync high.
- `V_BACK`, 17: blank lines between vsync and the first active line.
- `V_FRONT`, 10: blank lines after the last active line.
- `clk` in 1: byte clock. One output byte per cycle.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: run frames. Sampled only at frame boundaries.
- `pattern_sel` in 2: 0 = colour bars, 1 = ramp, 2 = checkerboard, 3 = solid.
- `solid_rgb` in 16: RGB565 colour for pattern 3.
- `dvp_vsync` out 1: high during the vsync lines.
- `dvp_href` out 1: high during active bytes.
- `dvp_data` out 8: byte stream.
- `frame_cnt` out 16: count of completed frames, wraps.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- LINE_LEN = 2·H_ACTIVE + H_BLANK.
- h counter: 0..LINE_LEN-1.
- v counter: counts lines within the current state.
- States: IDLE → VSYNC (VSYNC_LINES lines) → VBACK (V_BACK lines) → ACTIVE (V_ACTIVE lines) → VFRONT (V_FRONT lines).
- IDLE: a rising edge with `enable`=1 enters VSYNC with h=0, v=0. The same edge latches `pattern_sel` and `solid_rgb`.
- End of VFRONT, last cycle:
  - `frame_cnt` increments.
  - `enable`=1 → VSYNC; latches are re-sampled.
  - `enable`=0 → IDLE.
  - Deasserting `enable` mid-frame never truncates the frame.
- `dvp_vsync` = 1 for every cycle of VSYNC.
- `dvp_href` = 1 in ACTIVE when h < 2·H_ACTIVE.
- Pixel coordinates: x = h>>1, y = active line index.
- Byte order: even h outputs {R[4:0],G[5:3]}; odd h outputs {G[2:0],B[4:0]}.
- `dvp_data` = 0 whenever href is low.
- Pattern 0, colour bars: bar = x·8/H_ACTIVE.
  - Bar colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - Implement as a compare against seven precomputed boundaries. No divider.
- Pattern 1, ramp: R = x[7:3], G = x[7:2], B = x[7:3].
- Pattern 2, checkerboard: (x[5]^y[5]) ? FFFF : 0000.
- Pattern 3, solid: latched `solid_rgb`.
- Reset values: all outputs 0, state IDLE, counters 0, latches 0.

## Timing
- Frame length in cycles: LINE_LEN · (VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT). No gaps between back-to-back frames.
- Latency: `dvp_vsync`=1 on the first cycle after the edge that samples `enable`=1 in IDLE.
- First `dvp_href`=1 cycle: LINE_LEN·(VSYNC_LINES+V_BACK) cycles after the first vsync-high cycle.
- Within each active line, href is contiguous for exactly 2·H_ACTIVE cycles, starting at h=0.
- `frame_cnt` updates on the edge that leaves VFRONT.
  - It is visible in the same cycle vsync rises for the next frame.
  - It is visible in the same cycle `busy` falls.
- Wrap: `frame_cnt` goes FFFF → 0000.
- Reset mid-frame: all outputs drop to 0 immediately (asynchronous). Restart requires `enable` in IDLE.
- Parameters with zero line counts are illegal. No check is made.

## Configuration
- `DVP_PATTERN_FRAME_STAMP_EN` defined: pixel (0,0) of each frame carries `frame_cnt` (value before increment) instead of the pattern colour, high byte first. The downstream checker uses this to detect dropped or repeated frames.
- Not defined: every pixel carries the pattern colour, and no stamp logic is synthesised.

## Test plan
Small parameters for all scenarios: H_ACTIVE=16, H_BLANK=4, V_ACTIVE=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1. This gives LINE_LEN=36 and 252 cycles per frame.

- Reset then `enable`=1: vsync high for cycles 1–36. First href at cycle 73, lasting 32 cycles. `busy` high. `frame_cnt`=1 after 252 cycles.
- Pattern 0: line 0 bytes are FF,FF,FF,FF (bar 0, x=0..1), then FF,E0 at x=2 (bar 1). The last pixel, x=15, is 00,00.
- Pattern 2 with H_ACTIVE=64, V_ACTIVE=64:
  - x=32, y=0 gives FF,FF.
  - x=32, y=32 gives 00,00.
  - href low → data 00.
- Pattern 3, `solid_rgb`=1234: every active byte pair is 12,34.
  - Changing `solid_rgb` mid-frame has no effect until the next frame.
  - With stamp enabled, frame 2 pixel (0,0) is 00,01.
- Deassert `enable` mid-ACTIVE: the frame completes all 252 cycles, then IDLE and `busy`=0.
  - Assert `reset_n`=0 mid-line: vsync, href, data and `frame_cnt` all 0 the same cycle.
- Preload `frame_cnt`=FFFF by forcing: the next frame end gives 0000, with continuous back-to-back vsync.

Source files
------------

// File: rtl/cmos_dvp_pattern_gen_if.sv
// DVP byte-stream bundle: vsync, href and 8-bit data as seen by a CMOS capture path.
interface cmos_dvp_pattern_gen_if;
   logic       dvp_vsync;
   logic       dvp_href;
   logic [7:0] dvp_data;

   modport master (output dvp_vsync, output dvp_href, output dvp_data);
   modport slave  (input  dvp_vsync, input  dvp_href, input  dvp_data);
endinterface

// File: rtl/cmos_dvp_pattern_gen.sv
// Synthetic OV7670-style DVP source producing RGB565 test patterns, one byte per clk.
// Optional macro DVP_PATTERN_FRAME_STAMP_EN: pixel (0,0) carries frame_cnt instead of the pattern.
//
// state    | meaning
// S_IDLE   | stopped, waiting for enable
// S_VSYNC  | vsync lines, dvp_vsync high
// S_VBACK  | blank lines between vsync and the first active line
// S_ACTIVE | active lines, href high for the first 2*H_ACTIVE bytes
// S_VFRONT | blank lines after the last active line
module cmos_dvp_pattern_gen #(
   parameter int H_ACTIVE    = 640,
   parameter int H_BLANK     = 288,
   parameter int V_ACTIVE    = 480,
   parameter int VSYNC_LINES = 3,
   parameter int V_BACK      = 17,
   parameter int V_FRONT     = 10
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic [1:0]                    pattern_sel,
   input  logic [15:0]                   solid_rgb,
   cmos_dvp_pattern_gen_if.master        dvp,
   output logic [15:0]                   frame_cnt,
   output logic                          busy
);
   localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
   localparam int H_W      = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
   localparam int V_MAX_A  = (V_ACTIVE > V_BACK) ? V_ACTIVE : V_BACK;
   localparam int V_MAX_B  = (VSYNC_LINES > V_FRONT) ? VSYNC_LINES : V_FRONT;
   localparam int V_MAX    = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;
   localparam int V_W      = (V_MAX > 1) ? $clog2(V_MAX) : 1;

   typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

   state_t         state, state_nxt;
   logic [H_W-1:0] h, h_nxt;
   logic [V_W-1:0] v, v_nxt;
   logic           latch_en, frame_done, line_end, last_line;
   logic [1:0]     pat_sel_q;
   logic [15:0]    solid_q, frame_cnt_q;
   logic [15:0]    x, pix;
   logic           y_bit5, href_nxt;
   logic [2:0]     bar;
   logic [7:0]     data_nxt;

   // First x of bar k is ceil(k*H_ACTIVE/8); comparing against these avoids a divider.
   function automatic logic [15:0] bar_bound(input int k);
      return 16'((k * H_ACTIVE + 7) / 8);
   endfunction

   always_comb begin
      state_nxt  = state;
      h_nxt      = h;
      v_nxt      = v;
      latch_en   = 1'b0;
      frame_done = 1'b0;
      line_end   = (h == H_W'(LINE_LEN - 1));
      last_line  = 1'b0;
      case (state)
         S_VSYNC:  last_line = (v == V_W'(VSYNC_LINES - 1));
         S_VBACK:  last_line = (v == V_W'(V_BACK - 1));
         S_ACTIVE: last_line = (v == V_W'(V_ACTIVE - 1));
         S_VFRONT: last_line = (v == V_W'(V_FRONT - 1));
         default:  last_line = 1'b0;
      endcase
      if (state == S_IDLE) begin
         h_nxt = '0;
         v_nxt = '0;
         if (enable) begin
            state_nxt = S_VSYNC;
            latch_en  = 1'b1;
         end
      end else if (line_end) begin
         h_nxt = '0;
         if (last_line) begin
            v_nxt = '0;
            case (state)
               S_VSYNC:  state_nxt = S_VBACK;
               S_VBACK:  state_nxt = S_ACTIVE;
               S_ACTIVE: state_nxt = S_VFRONT;
               S_VFRONT: begin
                  frame_done = 1'b1;
                  if (enable) begin
                     state_nxt = S_VSYNC;
                     latch_en  = 1'b1;
                  end else begin
                     state_nxt = S_IDLE;
                  end
               end
               default:  state_nxt = S_IDLE;
            endcase
         end else begin
            v_nxt = v + 1'b1;
         end
      end else begin
         h_nxt = h + 1'b1;
      end
   end

   // Outputs are computed from the next position so the registered stream lines up with state.
   always_comb begin
      x        = 16'(h_nxt >> 1);
      y_bit5   = ((int'(v_nxt) / 32) % 2) != 0;
      href_nxt = (state_nxt == S_ACTIVE) && (int'(h_nxt) < 2 * H_ACTIVE);
      bar      = 3'd0;
      for (int k = 1; k < 8; k++) begin
         if (x >= bar_bound(k)) bar = 3'(k);
      end
      case (pat_sel_q)
         2'd0: begin
            case (bar)
               3'd0:    pix = 16'hFFFF;
               3'd1:    pix = 16'hFFE0;
               3'd2:    pix = 16'h07FF;
               3'd3:    pix = 16'h07E0;
               3'd4:    pix = 16'hF81F;
               3'd5:    pix = 16'hF800;
               3'd6:    pix = 16'h001F;
               default: pix = 16'h0000;
            endcase
         end
         2'd1:    pix = {x[7:3], x[7:2], x[7:3]};
         2'd2:    pix = (x[5] ^ y_bit5) ? 16'hFFFF : 16'h0000;
         default: pix = solid_q;
      endcase
`ifdef DVP_PATTERN_FRAME_STAMP_EN
      if (state_nxt == S_ACTIVE && v_nxt == '0 && x == 16'd0) pix = frame_cnt_q;
`endif
      data_nxt = href_nxt ? (h_nxt[0] ? pix[7:0] : pix[15:8]) : 8'h00;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         h             <= '0;
         v             <= '0;
         pat_sel_q     <= 2'd0;
         solid_q       <= 16'h0000;
         frame_cnt_q   <= 16'h0000;
         busy          <= 1'b0;
         dvp.dvp_vsync <= 1'b0;
         dvp.dvp_href  <= 1'b0;
         dvp.dvp_data  <= 8'h00;
      end else begin
         state         <= state_nxt;
         h             <= h_nxt;
         v             <= v_nxt;
         if (latch_en) begin
            pat_sel_q <= pattern_sel;
            solid_q   <= solid_rgb;
         end
         if (frame_done) frame_cnt_q <= frame_cnt_q + 16'd1;
         busy          <= (state_nxt != S_IDLE);
         dvp.dvp_vsync <= (state_nxt == S_VSYNC);
         dvp.dvp_href  <= href_nxt;
         dvp.dvp_data  <= data_nxt;
      end
   end

   assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_cmos_dvp_pattern_gen.sv
// Directed bench for cmos_dvp_pattern_gen: small 16x4 instance plus a 64x64 instance for the checkerboard.
module tb_cmos_dvp_pattern_gen;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        en_s = 1'b0, en_b = 1'b0;
   logic [1:0]  sel_s = 2'd0, sel_b = 2'd0;
   logic [15:0] solid_s = 16'h0000, solid_b = 16'h0000;
   logic [15:0] fc_s, fc_b;
   logic        busy_s, busy_b;
   int          n_total = 0, n_pass = 0, n_fail = 0;
   int          cyc = 0, base = 0;

`ifdef DVP_PATTERN_FRAME_STAMP_EN
   localparam logic [7:0] P00_HI = 8'h00, P00_LO = 8'h01;
`else
   localparam logic [7:0] P00_HI = 8'h12, P00_LO = 8'h34;
`endif

   cmos_dvp_pattern_gen_if dvp_s ();
   cmos_dvp_pattern_gen_if dvp_b ();

   cmos_dvp_pattern_gen #(.H_ACTIVE(16), .H_BLANK(4), .V_ACTIVE(4),
                          .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)) dut (
      .clk(clk), .reset_n(reset_n), .enable(en_s), .pattern_sel(sel_s),
      .solid_rgb(solid_s), .dvp(dvp_s), .frame_cnt(fc_s), .busy(busy_s));

   cmos_dvp_pattern_gen #(.H_ACTIVE(64), .H_BLANK(4), .V_ACTIVE(64),
                          .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)) dut_chk (
      .clk(clk), .reset_n(reset_n), .enable(en_b), .pattern_sel(sel_b),
      .solid_rgb(solid_b), .dvp(dvp_b), .frame_cnt(fc_b), .busy(busy_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Frame cycle k is observed on the falling edge after the k-th rising edge since base.
   task automatic at(input int k);
      while (cyc < base + k) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_vsync", 16'(dvp_s.dvp_vsync), 16'h0);
      chk("rst_href",  16'(dvp_s.dvp_href),  16'h0);
      chk("rst_data",  16'(dvp_s.dvp_data),  16'h0);
      chk("rst_fc",    fc_s,                 16'h0);
      chk("rst_busy",  16'(busy_s),          16'h0);

      // Frame 1: colour bars
      reset_n = 1'b1;
      @(negedge clk);
      sel_s = 2'd0; en_s = 1'b1; base = cyc;
      at(1);   chk("vs_first",  16'(dvp_s.dvp_vsync), 16'h1);
               chk("busy_on",   16'(busy_s), 16'h1);
      at(36);  chk("vs_last",   16'(dvp_s.dvp_vsync), 16'h1);
      at(37);  chk("vs_off",    16'(dvp_s.dvp_vsync), 16'h0);
      at(72);  chk("href_pre",  16'(dvp_s.dvp_href), 16'h0);
      at(73);  chk("href_first",16'(dvp_s.dvp_href), 16'h1);
               chk("bar_h0",    16'(dvp_s.dvp_data), 16'hFF);
      at(74);  chk("bar_h1",    16'(dvp_s.dvp_data), 16'hFF);
      at(75);  chk("bar_h2",    16'(dvp_s.dvp_data), 16'hFF);
      at(76);  chk("bar_h3",    16'(dvp_s.dvp_data), 16'hFF);
      at(77);  chk("bar1_hi",   16'(dvp_s.dvp_data), 16'hFF);
      at(78);  chk("bar1_lo",   16'(dvp_s.dvp_data), 16'hE0);
      at(103); chk("bar7_hi",   16'(dvp_s.dvp_data), 16'h00);
               chk("href_h30",  16'(dvp_s.dvp_href), 16'h1);
      at(104); chk("bar7_lo",   16'(dvp_s.dvp_data), 16'h00);
               chk("href_h31",  16'(dvp_s.dvp_href), 16'h1);
      at(105); chk("href_blank",16'(dvp_s.dvp_href), 16'h0);
               chk("data_blank",16'(dvp_s.dvp_data), 16'h00);
      at(200); sel_s = 2'd3; solid_s = 16'h1234;
      at(252); chk("f1_end_fc", fc_s, 16'h0);
               chk("f1_end_vs", 16'(dvp_s.dvp_vsync), 16'h0);
               chk("f1_end_busy", 16'(busy_s), 16'h1);
      at(253); chk("f2_vs",     16'(dvp_s.dvp_vsync), 16'h1);
               chk("f2_fc",     fc_s, 16'h1);

      // Frame 2: solid colour, mid-frame changes ignored
      at(325); chk("p00_hi",    16'(dvp_s.dvp_data), 16'(P00_HI));
      at(326); chk("p00_lo",    16'(dvp_s.dvp_data), 16'(P00_LO));
      at(327); chk("solid_hi",  16'(dvp_s.dvp_data), 16'h12);
      at(328); chk("solid_lo",  16'(dvp_s.dvp_data), 16'h34);
      at(330); solid_s = 16'h5678;
      at(361); chk("solid_l1_hi", 16'(dvp_s.dvp_data), 16'h12);
      at(362); chk("solid_l1_lo", 16'(dvp_s.dvp_data), 16'h34);
      at(370); en_s = 1'b0;
      at(504); chk("f2_last_busy", 16'(busy_s), 16'h1);
      at(505); chk("idle_busy", 16'(busy_s), 16'h0);
               chk("idle_vs",   16'(dvp_s.dvp_vsync), 16'h0);
               chk("idle_fc",   fc_s, 16'h2);

      // Frame 3: new latch values, then async reset mid-line
      repeat (3) @(negedge clk);
      en_s = 1'b1; base = cyc;
      at(75);  chk("f3_hi",     16'(dvp_s.dvp_data), 16'h56);
               chk("f3_href",   16'(dvp_s.dvp_href), 16'h1);
      at(76);  chk("f3_lo",     16'(dvp_s.dvp_data), 16'h78);
      #2 reset_n = 1'b0; en_s = 1'b0;
      #1;
      chk("arst_vsync", 16'(dvp_s.dvp_vsync), 16'h0);
      chk("arst_href",  16'(dvp_s.dvp_href),  16'h0);
      chk("arst_data",  16'(dvp_s.dvp_data),  16'h0);
      chk("arst_fc",    fc_s,                 16'h0);
      chk("arst_busy",  16'(busy_s),          16'h0);

      // Frame counter wrap with back-to-back frames
      @(negedge clk); reset_n = 1'b1;
      repeat (2) @(negedge clk);
      en_s = 1'b1; base = cyc;
      at(100); force dut.frame_cnt_q = 16'hFFFF;
      at(101); release dut.frame_cnt_q;
               chk("wrap_pre",  fc_s, 16'hFFFF);
      at(252); chk("wrap_end_fc", fc_s, 16'hFFFF);
               chk("wrap_end_vs", 16'(dvp_s.dvp_vsync), 16'h0);
      at(253); chk("wrap_fc",   fc_s, 16'h0000);
               chk("wrap_vs",   16'(dvp_s.dvp_vsync), 16'h1);
               chk("wrap_busy", 16'(busy_s), 16'h1);
      en_s = 1'b0;

      // 64x64 checkerboard
      @(negedge clk);
      sel_b = 2'd2; en_b = 1'b1; base = cyc;
      at(2);    en_b = 1'b0;
      at(329);  chk("chk_x32y0_hi",  16'(dvp_b.dvp_data), 16'hFF);
      at(330);  chk("chk_x32y0_lo",  16'(dvp_b.dvp_data), 16'hFF);
      at(393);  chk("chk_blank_href",16'(dvp_b.dvp_href), 16'h0);
                chk("chk_blank_data",16'(dvp_b.dvp_data), 16'h00);
      at(4489); chk("chk_x0y32_hi",  16'(dvp_b.dvp_data), 16'hFF);
      at(4553); chk("chk_x32y32_hi", 16'(dvp_b.dvp_data), 16'h00);
      at(4554); chk("chk_x32y32_lo", 16'(dvp_b.dvp_data), 16'h00);
                chk("chk_href",      16'(dvp_b.dvp_href), 16'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
